// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters to a single UART
// transmitter, with optional channel locking and a busy-handshake timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_lock,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_strobe,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked,
  output logic                       err_timeout
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [CW-1:0]      wait_cnt;
  logic [NUM_REQ-1:0] grant_mask;
  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [GW-1:0]      win_idx;
  logic [7:0]         win_byte;
  logic               win_lock;
  logic               accept;
  logic               lock_release;
  logic               timeout;

  // Search order starts just after the last grant and wraps modulo NUM_REQ,
  // so non-power-of-two requester counts never reach a phantom index.
  always_comb begin : arbitrate
    // NOTE: every signal written in always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    grant_mask = '0;
    win_found  = 1'b0;
    win_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_mask[i] = (grant_id == GW'(i));
    end
    eligible = locked ? (req_valid & grant_mask) : req_valid;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && eligible[i] && ((int'(grant_id) + k) % NUM_REQ == i)) begin
          win_found = 1'b1;
          win_idx   = GW'(i);
        end
      end
    end
  end

  always_comb begin : winner_mux
    win_byte = '0;
    win_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == GW'(i)) begin
        win_byte = req_data[8*i +: 8];
        win_lock = req_lock[i];
      end
    end
  end

  assign accept       = (state == ST_IDLE) && !tx_busy && win_found;
  assign lock_release = (state == ST_IDLE) && locked && ((req_valid & grant_mask) == '0);
  assign timeout      = (state == ST_WAIT_BUSY) && !tx_busy &&
                        (wait_cnt == CW'(BUSY_TIMEOUT - 1));

  // Acceptance is visible in the IDLE cycle itself; gated by reset so no
  // requester sees a handshake while the block is being cleared.
  always_comb begin : ready_decode
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && i_rst_n && (win_idx == GW'(i));
    end
  end

  always_comb begin : next_state
    state_nxt = state;
    unique case (state)
      ST_IDLE:      if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE:     state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_busy)      state_nxt = ST_WAIT_DONE;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_WAIT_DONE: if (!tx_busy) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      tx_strobe   <= 1'b0;
      tx_data     <= '0;
      locked      <= 1'b0;
      err_timeout <= 1'b0;
      grant_id    <= GW'(NUM_REQ - 1);
      wait_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      tx_strobe <= accept;
      if (accept) begin
        tx_data  <= win_byte;
        grant_id <= win_idx;
        locked   <= win_lock;
      end else if (lock_release || timeout) begin
        locked <= 1'b0;
      end
      if (timeout) begin
        err_timeout <= 1'b1;
      end
      // Counts busy-low cycles spent waiting after the strobe.
      if (state == ST_WAIT_BUSY) begin
        wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 4;
  localparam int GW           = $clog2(NUM_REQ);

  logic                 i_clk     = 1'b0;
  logic                 i_rst_n   = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]   req_lock  = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_strobe;
  logic                 tx_busy   = 1'b0;
  logic [GW-1:0]        grant_id;
  logic                 locked;
  logic                 err_timeout;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_lock    (req_lock),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_strobe   (tx_strobe),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .locked      (locked),
    .err_timeout (err_timeout)
  );

  always #5 i_clk = ~i_clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    vec_cnt++;
    miss_cnt++;
    $display("FAIL %s: wait expired, awaited event never observed (cycle %0d)", name, cyc);
  endtask

  // ---------------- requesters: one FIFO of {lock,data} per requester
  logic [8:0] rq [NUM_REQ][$];

  task automatic push(input int i, input logic [7:0] d, input logic l);
    rq[i].push_back({l, d});
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  initial begin : requesters
    logic [NUM_REQ-1:0]   taken;
    logic [NUM_REQ-1:0]   v;
    logic [8*NUM_REQ-1:0] d;
    logic [NUM_REQ-1:0]   l;
    logic [8:0]           head;
    forever begin
      @(negedge i_clk);
      taken = req_ready;
      @(posedge i_clk);
      #1;
      v = '0; d = '0; l = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (taken[i[GW-1:0]] === 1'b1 && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          head = rq[i][0];
          v[i[GW-1:0]] = 1'b1;
          l[i[GW-1:0]] = head[8];
          d[{i[GW-1:0], 3'b000} +: 8] = head[7:0];
        end
      end
      req_valid = v;
      req_data  = d;
      req_lock  = l;
    end
  end

  // ---------------- transmitter: busy for tx_len cycles after each strobe
  int tx_len     = 3;
  bit force_busy = 1'b0;
  int busy_left  = 0;

  initial begin : transmitter
    logic s;
    forever begin
      @(negedge i_clk);
      s = tx_strobe;
      @(posedge i_clk);
      #1;
      if (s === 1'b1 && tx_len > 0) busy_left = tx_len;
      else if (busy_left > 0)       busy_left--;
      tx_busy = (busy_left > 0) || force_busy;
    end
  end

  // ---------------- transaction-level model of the arbiter
  logic [GW-1:0] m_grant      = GW'(NUM_REQ - 1);
  bit            m_locked     = 1'b0;
  bit            m_err        = 1'b0;
  logic [7:0]    m_data       = '0;
  bit            m_strobe_now = 1'b0;  // a byte was accepted last cycle
  int            m_low_seen   = -1;    // busy-low cycles seen since strobe, -1 if not awaiting
  bit            m_draining   = 1'b0;  // transmitter took the byte, waiting for it to finish
  bit            model_on     = 1'b0;

  function automatic bit channel_free();
    return !m_strobe_now && (m_low_seen < 0) && !m_draining;
  endfunction

  // Winner = eligible valid requester at the smallest forward distance from m_grant.
  function automatic int pick_winner();
    int best   = -1;
    int best_d = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      int d;
      d = (i - int'(m_grant) - 1 + 2 * NUM_REQ) % NUM_REQ;
      if (req_valid[i[GW-1:0]] === 1'b1 && (!m_locked || i == int'(m_grant)) && d < best_d) begin
        best   = i;
        best_d = d;
      end
    end
    return best;
  endfunction

  task automatic model_step(input int win);
    bit strobe_next;
    strobe_next = 1'b0;
    if (!i_rst_n) begin
      m_grant = GW'(NUM_REQ - 1); m_locked = 1'b0; m_err = 1'b0; m_data = '0;
      m_low_seen = -1; m_draining = 1'b0; m_strobe_now = 1'b0;
      return;
    end
    if (m_strobe_now) begin
      m_low_seen = 0;
    end else if (m_low_seen >= 0) begin
      if (tx_busy) begin
        m_low_seen = -1;
        m_draining = 1'b1;
      end else if (m_low_seen + 1 == BUSY_TIMEOUT) begin
        m_err = 1'b1; m_locked = 1'b0; m_low_seen = -1;
      end else begin
        m_low_seen++;
      end
    end else if (m_draining) begin
      if (!tx_busy) m_draining = 1'b0;
    end else if (m_locked && req_valid[m_grant] !== 1'b1) begin
      m_locked = 1'b0;
    end else if (!tx_busy && win >= 0) begin
      m_data      = req_data[{win[GW-1:0], 3'b000} +: 8];
      m_locked    = req_lock[win[GW-1:0]];
      m_grant     = win[GW-1:0];
      strobe_next = 1'b1;
    end
    m_strobe_now = strobe_next;
  endtask

  // ---------------- monitor records for directed checks
  int         grants[$];
  int         gcyc[$];
  int         strobes[$];
  logic [7:0] sdata[$];
  int         err_cyc       = -1;
  int         lock_last_cyc = -1;

  task automatic clear_mon();
    grants.delete(); gcyc.delete(); strobes.delete(); sdata.delete();
    err_cyc = -1; lock_last_cyc = -1;
  endtask

  initial begin : compare
    int                 win;
    logic [NUM_REQ-1:0] exp_ready;
    forever begin
      @(negedge i_clk);
      cyc++;
      win = pick_winner();
      exp_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        exp_ready[i[GW-1:0]] = i_rst_n && channel_free() && (tx_busy === 1'b0) && (win == i);
      end
      if (model_on) begin
        check("req_ready",   32'(req_ready),   32'(exp_ready));
        check("tx_strobe",   32'(tx_strobe),   32'(m_strobe_now));
        check("tx_data",     32'(tx_data),     32'(m_data));
        check("grant_id",    32'(grant_id),    32'(m_grant));
        check("locked",      32'(locked),      32'(m_locked));
        check("err_timeout", 32'(err_timeout), 32'(m_err));
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i[GW-1:0]] === 1'b1) begin
          grants.push_back(i);
          gcyc.push_back(cyc);
        end
      end
      if (tx_strobe === 1'b1) begin
        strobes.push_back(cyc);
        sdata.push_back(tx_data);
      end
      if (err_timeout === 1'b1 && err_cyc < 0) err_cyc = cyc;
      if (locked === 1'b1) lock_last_cyc = cyc;
      model_step(win);
      if (!i_rst_n) model_on = 1'b1;
    end
  end

  // ---------------- stimulus helpers
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge i_clk);
      n++;
      done = queues_empty() && (tx_busy === 1'b0) && channel_free();
    end
    if (!done) bound_fail(name);
    tick();
  endtask

  task automatic wait_grants(input string name, input int cnt, input int budget);
    int n;
    n = 0;
    while (grants.size() < cnt && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    if (grants.size() < cnt) bound_fail(name);
  endtask

  task automatic wait_err(input string name, input int budget);
    int n;
    n = 0;
    while (err_cyc < 0 && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    if (err_cyc < 0) bound_fail(name);
  endtask

  task automatic wait_busy(input string name, input int budget);
    int n;
    n = 0;
    while (tx_busy !== 1'b1 && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    if (tx_busy !== 1'b1) bound_fail(name);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // ---------------- directed scenarios
  initial begin : stimulus
    int exp_rr[5]    = '{0, 1, 2, 3, 0};
    int exp_rr_d[5]  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    int exp_lk[5]    = '{2, 2, 2, 0, 1};
    int exp_lk_d[5]  = '{8'h30, 8'h31, 8'h32, 8'h20, 8'h21};

    i_rst_n = 1'b0;
    repeat (3) tick();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("reset_grant_id",  32'(grant_id),    32'd3);
    check("reset_locked",    32'(locked),      32'd0);
    check("reset_err",       32'(err_timeout), 32'd0);
    check("reset_tx_data",   32'(tx_data),     32'd0);
    check("reset_tx_strobe", 32'(tx_strobe),   32'd0);
    tick();

    // Round robin with all four requesters pending and a 10-cycle transmitter.
    clear_mon();
    tx_len = 10;
    push(0, 8'hA0, 1'b0); push(0, 8'hA4, 1'b0);
    push(1, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(3, 8'hA3, 1'b0);
    wait_quiet("rr_drain", 400);
    check("rr_grant_count",  32'(grants.size()),  32'd5);
    check("rr_strobe_count", 32'(strobes.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check("rr_order", 32'(grants[k]), 32'(exp_rr[k]));
      check("rr_byte",  32'(sdata[k]),  32'(exp_rr_d[k]));
    end
    for (int k = 1; k < 5; k++) begin
      check("rr_spacing_ge13", 32'((strobes[k] - strobes[k-1]) >= 13), 32'd1);
    end

    // Locked burst from requester 2 while 0 and 1 wait.
    tx_len = 3;
    push(1, 8'h11, 1'b0);
    wait_quiet("pre_lock", 100);
    clear_mon();
    push(0, 8'h20, 1'b0); push(1, 8'h21, 1'b0);
    push(2, 8'h30, 1'b1); push(2, 8'h31, 1'b1); push(2, 8'h32, 1'b0);
    wait_quiet("lock_burst", 300);
    check("lock_grant_count", 32'(grants.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check("lock_order", 32'(grants[k]), 32'(exp_lk[k]));
      check("lock_byte",  32'(sdata[k]),  32'(exp_lk_d[k]));
    end

    // Lock owner stops requesting; req 3 must be granted the cycle after release.
    clear_mon();
    push(1, 8'h41, 1'b1);
    wait_grants("owner_grant", 1, 50);
    push(3, 8'h43, 1'b0);
    wait_quiet("lock_drop", 200);
    check("drop_first",  32'(grants[0]), 32'd1);
    check("drop_second", 32'(grants[1]), 32'd3);
    check("drop_timing", 32'(gcyc[1]),   32'(lock_last_cyc + 1));

    // Transmitter never goes busy: timeout five cycles after the strobe.
    clear_mon();
    tx_len = 0;
    push(0, 8'h55, 1'b1);
    wait_err("timeout_seen", 60);
    check("timeout_latency", 32'(err_cyc - strobes[0]), 32'd5);
    tx_len = 3;
    push(2, 8'h66, 1'b0);
    wait_quiet("after_timeout", 200);
    check("timeout_next_count", 32'(grants.size()), 32'd2);
    check("timeout_next_grant", 32'(grants[1]),     32'd2);
    check("timeout_next_byte",  32'(sdata[1]),      32'h66);
    check("err_sticky",         32'(err_timeout),   32'd1);

    // Reset while the transmitter is busy with a byte.
    clear_mon();
    tx_len = 10;
    push(1, 8'h77, 1'b0);
    wait_busy("busy_rise", 40);
    @(negedge i_clk);
    push(0, 8'h80, 1'b0); push(2, 8'h82, 1'b0);
    tick();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("mid_rst_strobe",  32'(tx_strobe),   32'd0);
    check("mid_rst_grant",   32'(grant_id),    32'd3);
    check("mid_rst_err",     32'(err_timeout), 32'd0);
    check("mid_rst_locked",  32'(locked),      32'd0);
    check("mid_rst_tx_data", 32'(tx_data),     32'd0);
    check("mid_rst_ready",   32'(req_ready),   32'd0);
    wait_quiet("post_reset", 200);
    check("post_rst_strobes", 32'(strobes.size()), 32'd3);
    check("post_rst_first",   32'(grants[1]),      32'd0);
    check("post_rst_second",  32'(grants[2]),      32'd2);

    // Busy held high across reset release: nothing accepted until it falls.
    force_busy = 1'b1;
    i_rst_n = 1'b0;
    push(1, 8'h99, 1'b0);
    tick();
    tick();
    i_rst_n = 1'b1;
    clear_mon();
    repeat (6) tick();
    check("busy_hold_no_grant", 32'(grants.size()), 32'd0);
    force_busy = 1'b0;
    wait_quiet("busy_release", 100);
    check("busy_release_count", 32'(grants.size()), 32'd1);
    check("busy_release_grant", 32'(grants[0]),     32'd1);
    check("busy_release_byte",  32'(sdata[0]),      32'h99);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of byte requesters (2..8).
REQ-002 The block SHALL have parameter BUSY_TIMEOUT, default 4, max cycles after strobe to wait for tx_busy rising.
REQ-003 The block SHALL have port i_clk, input, 1, sole clock, all logic on rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1, reset, synchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ, per-requester byte pending; held until matching req_ready.
REQ-006 The block SHALL have port req_data, input, 8*NUM_REQ, packed bytes, requester i at [8i+7:8i]; stable while req_valid[i].
REQ-007 The block SHALL have port req_lock, input, NUM_REQ, requester i wants to keep the channel after this byte.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ, one-cycle acceptance pulse per requester.
REQ-009 The block SHALL have port tx_data, output, 8, byte to transmitter, registered.
REQ-010 The block SHALL have port tx_strobe, output, 1, start pulse to transmitter.
REQ-011 The block SHALL have port tx_busy, input, 1, transmitter busy.
REQ-012 The block SHALL have port grant_id, output, clog2(NUM_REQ), index of last accepted requester.
REQ-013 The block SHALL have port locked, output, 1, channel held by grant_id.
REQ-014 The block SHALL have port err_timeout, output, 1, sticky: tx_busy never rose after a strobe.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-016 In IDLE with tx_busy low and at least one eligible req_valid, it SHALL accept one requester, pulse its req_ready for that cycle, register its byte into tx_data, update grant_id, and enter ISSUE.
REQ-017 IDLE with tx_busy high SHALL accept nothing and remain in IDLE.
REQ-018 Eligibility: when locked=0, all requesters are eligible; when locked=1, only grant_id is eligible.
REQ-019 Selection SHALL be round-robin: search starts at (grant_id+1) mod NUM_REQ, ascending with wrap; the first eligible valid wins.
REQ-020 At acceptance, locked SHALL be set to req_lock[winner].
REQ-021 In IDLE with locked=1 and req_valid[grant_id] low, locked SHALL clear that cycle and no byte is accepted; arbitration resumes next cycle.
REQ-022 ISSUE SHALL last exactly one cycle with tx_strobe=1, then go to WAIT_BUSY.
REQ-023 tx_strobe SHALL be 0 in all other states, so there is exactly one strobe per accepted byte.
REQ-024 In WAIT_BUSY, tx_busy high SHALL move the FSM to WAIT_DONE.
REQ-025 In WAIT_BUSY, if tx_busy stays low BUSY_TIMEOUT cycles after the strobe, err_timeout SHALL set, locked SHALL clear, and the FSM enters IDLE; the byte is dropped.
REQ-026 In WAIT_DONE, tx_busy low SHALL move the FSM to IDLE; the next acceptance occurs no earlier than that IDLE cycle.
REQ-027 Minimum spacing between strobes SHALL be 4 cycles: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-028 req_ready SHALL be one-hot or zero every cycle and SHALL never assert outside IDLE.
REQ-029 req_valid changes outside IDLE SHALL have no effect; only the accepting cycle samples req_data and req_lock.
REQ-030 Requester indices ≥ NUM_REQ SHALL never be granted; the grant_id wrap SHALL use modulo NUM_REQ, not a power of two.

Reset
REQ-031 While i_rst_n=0 at a clock edge, the block SHALL set: state=IDLE, tx_strobe=0, tx_data=0, req_ready=0, locked=0, err_timeout=0, grant_id=NUM_REQ-1 (requester 0 wins first).
REQ-032 Reset mid-transfer SHALL abandon the byte with no strobe issued after reset; the transmitter is allowed to finish independently.
REQ-033 err_timeout SHALL clear only by reset.

Verification
REQ-034 Reset, then req_valid=4'b1111 held, with a transmitter model that has busy for 10 cycles: grants in order 0,1,2,3,0; one req_ready pulse per strobe; strobe spacing ≥ 13 cycles.
REQ-035 Req 2 sends 3 bytes with req_lock=1,1,0 while req 0 and req 1 are valid: all three bytes of req 2 go out consecutively, then req 0 is granted.
REQ-036 Locked owner drops valid in IDLE while req 3 is valid: locked clears that cycle; req 3 is granted on the next cycle.
REQ-037 Model never raises busy, BUSY_TIMEOUT=4: err_timeout=1 five cycles after the strobe; FSM returns to IDLE; the next request is still served.
REQ-038 Assert i_rst_n=0 during WAIT_DONE: next cycle all outputs are at reset values; no stray strobe; after release, requester 0 is granted first.
REQ-039 tx_busy high at reset release while req_valid=1: no acceptance until tx_busy falls.
